// File: rtl/game_pkg.sv
// Shared definitions for the score keeper: FSM encodings, BCD limits and a
// BCD magnitude compare helper.
package game_pkg;

  typedef enum logic [1:0] {
    SK_IDLE = 2'd0,
    SK_PLAY = 2'd1,
    SK_HOLD = 2'd2,
    SK_OVER = 2'd3
  } sk_state_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // True when a > b for two 4-digit BCD values, compared MSD first.
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic result;
    logic decided;
    result  = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        result  = (a[i*4 +: 4] > b[i*4 +: 4]);
        decided = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/score_keeper_bcd4_add_sat.sv
// Combinational 4-digit BCD adder with a single-digit addend. A carry out of
// the most significant digit pins the result at 9999 instead of wrapping.
module bcd4_add_sat (
  input  logic [15:0] a_i,
  input  logic [3:0]  b_i,
  output logic [15:0] sum_o
);
  import game_pkg::*;

  logic [4:0]  dig;
  logic        carry;
  logic [15:0] raw;

  // Ripple the carry digit by digit, correcting each digit that exceeds 9.
  always_comb begin
    dig   = 5'd0;
    carry = 1'b0;
    raw   = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      dig = {1'b0, a_i[i*4 +: 4]} + {4'b0000, carry} + ((i == 0) ? {1'b0, b_i} : 5'd0);
      if (dig > 5'd9) begin
        dig   = dig - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[i*4 +: 4] = dig[3:0];
    end
    sum_o = carry ? BCD_MAX : raw;
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: tracks BCD score, high score and remaining lives from
// per-tick game events, and drives the 7-segment number bus and status LEDs.
// Handshake: there is none; brick_hit, ball_lost and game_start are plain
// levels qualified by tick, and every register updates only on the clock
// edge that sees tick=1.
module score_keeper #(
  parameter int LIVES       = 5,
  parameter int PTS_BRICK   = 1,
  parameter int LOST_HOLD   = 8,
  parameter int DISP_TOGGLE = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             game_start,
  input  logic             brick_hit,
  input  logic             ball_lost,
  output logic [15:0]      nums,
  output logic [LIVES-1:0] lives,
  output logic             playing,
  output logic             game_over,
  output logic             show_high,
  output logic [1:0]       dbg_state
);
  import game_pkg::*;

  localparam int HOLD_W = (LOST_HOLD > 1) ? $clog2(LOST_HOLD) : 1;
  localparam int DISP_W = (DISP_TOGGLE > 1) ? $clog2(DISP_TOGGLE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOST_HOLD - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_TOGGLE - 1);

  sk_state_e         state_q, state_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_q, high_d;
  logic [LIVES-1:0]  lives_q, lives_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              show_q, show_d;
  logic [15:0]       nums_q, nums_d;
  logic [15:0]       score_inc;

  bcd4_add_sat u_add (
    .a_i   (score_q),
    .b_i   (4'(PTS_BRICK)),
    .sum_o (score_inc)
  );

  // State and datapath registers; asynchronous reset returns to IDLE values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SK_IDLE;
      score_q <= 16'h0000;
      high_q  <= 16'h0000;
      lives_q <= '0;
      hold_q  <= '0;
      disp_q  <= '0;
      show_q  <= 1'b0;
      nums_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      show_q  <= show_d;
      nums_q  <= nums_d;
    end
  end

  // Next-state and datapath update, evaluated only on game ticks.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    show_d  = show_q;
    if (tick) begin
      case (state_q)
        SK_IDLE: begin
          if (game_start) begin
            state_d = SK_PLAY;
            score_d = 16'h0000;
            lives_d = '1;
          end
        end
        SK_PLAY: begin
          if (brick_hit) score_d = score_inc;
          if (ball_lost) begin
            lives_d = lives_q >> 1;
            if (lives_d == '0) begin
              // Same-tick brick score is already in score_d, so it counts
              // toward the high score.
              state_d = SK_OVER;
              high_d  = bcd_gt(score_d, high_q) ? score_d : high_q;
              disp_d  = '0;
              show_d  = 1'b0;
            end else begin
              state_d = SK_HOLD;
              hold_d  = HOLD_INIT;
            end
          end
        end
        SK_HOLD: begin
          if (brick_hit) score_d = score_inc;
          if (hold_q == '0) state_d = SK_PLAY;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        SK_OVER: begin
          if (game_start) begin
            state_d = SK_PLAY;
            score_d = 16'h0000;
            lives_d = '1;
            show_d  = 1'b0;
            disp_d  = '0;
          end else if (disp_q == DISP_LAST) begin
            disp_d = '0;
            show_d = ~show_q;
          end else begin
            disp_d = disp_q + DISP_W'(1);
          end
        end
        default: state_d = SK_IDLE;
      endcase
    end
    // Display mux is registered alongside state so nums never glitches.
    if (state_d == SK_IDLE) nums_d = 16'h0000;
    else                    nums_d = show_d ? high_d : score_d;
  end

  // Output decode from registered state.
  always_comb begin
    playing   = (state_q == SK_PLAY) || (state_q == SK_HOLD);
    game_over = (state_q == SK_OVER);
    nums      = nums_q;
    lives     = lives_q;
    show_high = show_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with hand-computed expected values.
module tb_score_keeper;
  import game_pkg::*;

  localparam int LH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, game_start, brick_hit, ball_lost;
  logic [15:0] nums;
  logic [4:0]  lives;
  logic        playing, game_over, show_high;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  score_keeper #(.LIVES(5), .PTS_BRICK(1), .LOST_HOLD(LH), .DISP_TOGGLE(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .game_start (game_start),
    .brick_hit  (brick_hit),
    .ball_lost  (ball_lost),
    .nums       (nums),
    .lives      (lives),
    .playing    (playing),
    .game_over  (game_over),
    .show_high  (show_high),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick_ev(input logic gs, input logic bh, input logic bl);
    @(negedge clk);
    tick = 1'b1; game_start = gs; brick_hit = bh; ball_lost = bl;
    @(posedge clk); #1;
    tick = 1'b0; game_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
  endtask

  task automatic run_ticks(input int n, input logic bh);
    @(negedge clk);
    tick = 1'b1; brick_hit = bh;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0; brick_hit = 1'b0;
  endtask

  // All event inputs asserted while tick stays low: must have no effect.
  task automatic idle_noise(input int n);
    @(negedge clk);
    tick = 1'b0; game_start = 1'b1; brick_hit = 1'b1; ball_lost = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    game_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
  endtask

  task automatic lose_all(input int n_lives);
    for (int i = 1; i < n_lives; i++) begin
      tick_ev(1'b0, 1'b0, 1'b1);
      run_ticks(LH, 1'b0);
    end
    tick_ev(1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; game_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nums", nums, 0);
    check("rst_lives", lives, 0);
    check("rst_playing", playing, 0);
    check("rst_over", game_over, 0);
    check("rst_show", show_high, 0);
    check("rst_state", dbg_state, SK_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // game_start without tick is not sampled
    idle_noise(4);
    check("idle_notick_state", dbg_state, SK_IDLE);
    check("idle_notick_nums", nums, 0);

    // Reset mid-PLAY with score 0x0042
    tick_ev(1'b1, 1'b0, 1'b0);
    check("t1_playing", playing, 1);
    check("t1_lives", lives, 5'b11111);
    check("t1_nums0", nums, 16'h0000);
    run_ticks(42, 1'b1);
    check("t1_nums42", nums, 16'h0042);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t1_async_nums", nums, 0);
    check("t1_async_lives", lives, 0);
    check("t1_async_playing", playing, 0);
    check("t1_async_state", dbg_state, SK_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // Twelve brick hits, scoreboarded, with tick-low noise in between
    tick_ev(1'b1, 1'b0, 1'b0);
    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
              16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};
    for (int i = 0; i < 12; i++) begin
      tick_ev(1'b0, 1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      check("t2_nums_step", nums, exp_v);
      if (i % 4 == 3) begin
        idle_noise(3);
        check("t2_nums_notick", nums, exp_v);
      end
    end
    check("t2_nums", nums, 16'h0012);
    check("t2_lives", lives, 5'b11111);
    check("t2_playing", playing, 1);
    tick_ev(1'b1, 1'b0, 1'b0);
    check("t2_start_ignored", nums, 16'h0012);

    // Life loss, second loss inside hold ignored, PLAY after LH ticks
    tick_ev(1'b0, 1'b0, 1'b1);
    check("t4_lives1", lives, 5'b01111);
    check("t4_hold", dbg_state, SK_HOLD);
    check("t4_playing", playing, 1);
    tick_ev(1'b0, 1'b0, 1'b0);
    tick_ev(1'b0, 1'b0, 1'b0);
    tick_ev(1'b0, 1'b0, 1'b1);
    check("t4_lives2", lives, 5'b01111);
    tick_ev(1'b0, 1'b1, 1'b0);
    check("t4_hold_score", nums, 16'h0013);
    run_ticks(3, 1'b0);
    check("t4_still_hold", dbg_state, SK_HOLD);
    tick_ev(1'b0, 1'b0, 1'b0);
    check("t4_play_again", dbg_state, SK_PLAY);

    // Saturation at 9999
    run_ticks(9985, 1'b1);
    check("t3_9998", nums, 16'h9998);
    tick_ev(1'b0, 1'b1, 1'b0);
    check("t3_9999", nums, 16'h9999);
    run_ticks(2, 1'b1);
    check("t3_sat", nums, 16'h9999);
    check("t3_lives", lives, 5'b01111);
    reset_pulse();

    // Simultaneous brick and last-life loss
    tick_ev(1'b1, 1'b0, 1'b0);
    run_ticks(7, 1'b1);
    check("t5_nums7", nums, 16'h0007);
    for (int i = 0; i < 4; i++) begin
      tick_ev(1'b0, 1'b0, 1'b1);
      run_ticks(LH, 1'b0);
    end
    check("t5_one_life", lives, 5'b00001);
    tick_ev(1'b0, 1'b1, 1'b1);
    check("t5_nums8", nums, 16'h0008);
    check("t5_lives0", lives, 0);
    check("t5_over", game_over, 1);
    check("t5_not_playing", playing, 0);
    check("t5_show0", show_high, 0);
    run_ticks(39, 1'b0);
    check("t5_show_39", show_high, 0);
    tick_ev(1'b0, 1'b0, 1'b0);
    check("t5_show_40", show_high, 1);
    check("t5_high", nums, 16'h0008);

    // High score retained across a lower-scoring game
    tick_ev(1'b1, 1'b0, 1'b0);
    check("t6_restart_play", playing, 1);
    check("t6_restart_show", show_high, 0);
    check("t6_restart_nums", nums, 16'h0000);
    check("t6_restart_lives", lives, 5'b11111);
    run_ticks(30, 1'b1);
    check("t6_nums30", nums, 16'h0030);
    lose_all(5);
    check("t6_over1", game_over, 1);
    run_ticks(40, 1'b0);
    check("t6_show1", show_high, 1);
    check("t6_high30", nums, 16'h0030);
    tick_ev(1'b1, 1'b0, 1'b0);
    check("t6_start_show", show_high, 0);
    check("t6_start_nums", nums, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      tick_ev(1'b0, 1'b1, 1'b0);
      if (i == 5) begin
        idle_noise(5);
        check("t6_notick_nums", nums, 16'h0006);
        check("t6_notick_state", dbg_state, SK_PLAY);
      end
    end
    check("t6_nums12", nums, 16'h0012);
    lose_all(5);
    check("t6_over2", game_over, 1);
    check("t6_over2_nums", nums, 16'h0012);
    check("t6_over2_show", show_high, 0);
    idle_noise(6);
    check("t6_over_notick", dbg_state, SK_OVER);
    check("t6_over_notick_nums", nums, 16'h0012);
    run_ticks(40, 1'b0);
    check("t6_show2", show_high, 1);
    check("t6_high_kept", nums, 16'h0030);
    run_ticks(40, 1'b0);
    check("t6_show_back", show_high, 0);
    check("t6_score_back", nums, 16'h0012);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
